// File: rtl/bus_seq_pkg.sv
// ----------------------------------------------------------------------------
// bus_seq_pkg
//   Shared definitions for the external bus sequencer and its wait timer.
//   - bus_state_t : machine-cycle state encoding (IDLE=0, T1..T4 = 1..4, TW=5)
//   - RDATA_RST   : value shown on RDATA after reset (floating bus reads as 1s)
//   - WAIT_CNT_W  : width of the wait-state counter
// ----------------------------------------------------------------------------
package bus_seq_pkg;

    // Machine-cycle states. TW is numbered after T4 so the T1..T4 sequence
    // keeps its natural numbering.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,  // address setup
        ST_T2   = 3'd2,  // strobe asserted
        ST_T3   = 3'd3,  // sample read data
        ST_T4   = 3'd4,  // release strobes, acknowledge
        ST_TW   = 3'd5   // wait state
    } bus_state_t;

    localparam logic [7:0] RDATA_RST  = 8'hFF;
    localparam int         WAIT_CNT_W = 4;

endpackage : bus_seq_pkg

// File: rtl/bus_wait_timer.sv
// ----------------------------------------------------------------------------
// bus_wait_timer
//   Counts wait-state cycles and flags the cycle in which the count reaches
//   the configured limit.
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   clear   in   synchronous clear of the count (has priority over inc)
//   inc     in   count one wait-state cycle at the next edge
//   limit   in   number of wait-state cycles allowed (1..15)
//   expire  out  combinational pulse: this increment reaches the limit;
//                derived only from the count flop and the caller's inc
// ----------------------------------------------------------------------------
module bus_wait_timer
    import bus_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  inc,
    input  logic [WAIT_CNT_W-1:0] limit,
    output logic                  expire
);

    logic [WAIT_CNT_W-1:0] count;
    logic [WAIT_CNT_W-1:0] count_inc;

    assign count_inc = count + WAIT_CNT_W'(1);

    // The caller acts on expire at the same edge that would have stored
    // count_inc, so the N-th wait cycle is the one that ends the wait.
    assign expire = inc && (count_inc == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !expire) begin
            count <= count_inc;
        end
    end

endmodule : bus_wait_timer

// File: rtl/ext_bus_sequencer.sv
// ----------------------------------------------------------------------------
// ext_bus_sequencer
//   Runs external memory bus cycles for the core. A request (REQ with WE,
//   ADDR_IN, WDATA) is registered and sequenced through T1 (address setup),
//   T2 (strobe), optional TW (wait), T3 (sample) and T4 (release + ACK).
//   All outputs come straight from flops so the external strobes and the
//   data-bus output enable are glitch-free. Test1 disconnects the core from
//   the bus: an in-flight cycle is abandoned and new requests are ignored.
// Parameters:
//   ADDR_W    address width
//   DATA_W    data width
//   MAX_WAIT  wait states allowed before forced completion (1..15)
// Ports:
//   CLK      in   core clock, all state changes on rising edge
//   nRES     in   asynchronous active-low reset
//   REQ      in   bus request, held until ACK
//   WE       in   1 = write, 0 = read (sampled with REQ)
//   ADDR_IN  in   request address (sampled with REQ)
//   WDATA    in   write data (sampled with REQ)
//   ACK      out  one-cycle completion pulse (during T4)
//   RDATA    out  read data, valid from ACK until the next read's ACK
//   BUSY     out  1 while not IDLE
//   A        out  external address, stable T1..T4
//   D_IN     in   sampled external data bus
//   D_OUT    out  write data toward the bus
//   D_OE     out  drive D_OUT onto the bus (write cycles, T1..T4)
//   nRD      out  read strobe, active-low, T2..T3
//   nWR      out  write strobe, active-low, T2..T3
//   WAIT_n   in   0 = target requests a wait state (looked at in T2/TW)
//   Test1    in   1 = bus disabled
//   TIMEOUT  out  sticky: a wait limit forced completion; cleared by reset
// ----------------------------------------------------------------------------
module ext_bus_sequencer
    import bus_seq_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 3
) (
    input  logic              CLK,
    input  logic              nRES,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic [DATA_W-1:0] WDATA,
    output logic              ACK,
    output logic [DATA_W-1:0] RDATA,
    output logic              BUSY,
    output logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D_IN,
    output logic [DATA_W-1:0] D_OUT,
    output logic              D_OE,
    output logic              nRD,
    output logic              nWR,
    input  logic              WAIT_n,
    input  logic              Test1,
    output logic              TIMEOUT
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

    bus_state_t state;
    logic       we_q;        // direction of the cycle in flight
    logic       start_ok;    // a new cycle may be accepted at this edge
    logic       wait_inc;
    logic       wait_clear;
    logic       wait_expire;

    assign start_ok = REQ && !Test1;

    // Only wait cycles in which the target is still stalling are counted;
    // leaving TW for any reason restarts the count from zero.
    assign wait_inc   = (state == ST_TW) && !WAIT_n;
    assign wait_clear = (state != ST_TW);

    bus_wait_timer u_wait_timer (
        .clk    (CLK),
        .rst_n  (nRES),
        .clear  (wait_clear),
        .inc    (wait_inc),
        .limit  (WAIT_LIMIT),
        .expire (wait_expire)
    );

    // NOTE: every register here is assigned with <= so all branches see the
    // values from before the edge; mixing in = would make results depend on
    // statement order inside this block.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            A       <= '0;
            D_OUT   <= '0;
            D_OE    <= 1'b0;
            nRD     <= 1'b1;
            nWR     <= 1'b1;
            ACK     <= 1'b0;
            BUSY    <= 1'b0;
            RDATA   <= DATA_W'(RDATA_RST);
            TIMEOUT <= 1'b0;
        end else begin
            // ACK is only ever raised for the single cycle spent in T4.
            ACK <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state <= ST_T1;
                        we_q  <= WE;
                        A     <= ADDR_IN;
                        D_OUT <= WDATA;
                        D_OE  <= WE;
                        BUSY  <= 1'b1;
                    end
                end

                ST_T1: begin
                    if (Test1) begin
                        state <= ST_IDLE;
                        D_OE  <= 1'b0;
                        BUSY  <= 1'b0;
                    end else begin
                        state <= ST_T2;
                        nRD   <= we_q;
                        nWR   <= !we_q;
                    end
                end

                ST_T2: begin
                    if (Test1) begin
                        state <= ST_IDLE;
                        nRD   <= 1'b1;
                        nWR   <= 1'b1;
                        D_OE  <= 1'b0;
                        BUSY  <= 1'b0;
                    end else if (!WAIT_n) begin
                        state <= ST_TW;
                    end else begin
                        state <= ST_T3;
                    end
                end

                ST_TW: begin
                    if (Test1) begin
                        state <= ST_IDLE;
                        nRD   <= 1'b1;
                        nWR   <= 1'b1;
                        D_OE  <= 1'b0;
                        BUSY  <= 1'b0;
                    end else if (WAIT_n) begin
                        state <= ST_T3;
                    end else if (wait_expire) begin
                        // Target never released: finish the cycle anyway.
                        state   <= ST_T3;
                        TIMEOUT <= 1'b1;
                    end
                end

                ST_T3: begin
                    if (Test1) begin
                        // Abandoned cycle: RDATA keeps the previous read.
                        state <= ST_IDLE;
                        nRD   <= 1'b1;
                        nWR   <= 1'b1;
                        D_OE  <= 1'b0;
                        BUSY  <= 1'b0;
                    end else begin
                        state <= ST_T4;
                        nRD   <= 1'b1;
                        nWR   <= 1'b1;
                        ACK   <= 1'b1;
                        if (!we_q) begin
                            RDATA <= D_IN;
                        end
                    end
                end

                ST_T4: begin
                    if (start_ok) begin
                        // Back-to-back: straight into the next T1.
                        state <= ST_T1;
                        we_q  <= WE;
                        A     <= ADDR_IN;
                        D_OUT <= WDATA;
                        D_OE  <= WE;
                    end else begin
                        state <= ST_IDLE;
                        D_OE  <= 1'b0;
                        BUSY  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    nRD   <= 1'b1;
                    nWR   <= 1'b1;
                    D_OE  <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule : ext_bus_sequencer

// File: tb/tb_ext_bus_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ext_bus_sequencer
//   Directed stimulus for ext_bus_sequencer. Each issued request pushes its
//   expected completion (ACK cycle, address, RDATA) into a queue; a monitor
//   on the falling clock edge pops and compares whenever ACK is high.
//   Bus-pin behaviour inside each cycle is checked directly by the stimulus.
// ----------------------------------------------------------------------------
module tb_ext_bus_sequencer;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    logic              CLK;
    logic              nRES;
    logic              REQ;
    logic              WE;
    logic [ADDR_W-1:0] ADDR_IN;
    logic [DATA_W-1:0] WDATA;
    logic              ACK;
    logic [DATA_W-1:0] RDATA;
    logic              BUSY;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] D_IN;
    logic [DATA_W-1:0] D_OUT;
    logic              D_OE;
    logic              nRD;
    logic              nWR;
    logic              WAIT_n;
    logic              Test1;
    logic              TIMEOUT;

    ext_bus_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (3)
    ) dut (
        .CLK     (CLK),
        .nRES    (nRES),
        .REQ     (REQ),
        .WE      (WE),
        .ADDR_IN (ADDR_IN),
        .WDATA   (WDATA),
        .ACK     (ACK),
        .RDATA   (RDATA),
        .BUSY    (BUSY),
        .A       (A),
        .D_IN    (D_IN),
        .D_OUT   (D_OUT),
        .D_OE    (D_OE),
        .nRD     (nRD),
        .nWR     (nWR),
        .WAIT_n  (WAIT_n),
        .Test1   (Test1),
        .TIMEOUT (TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Rising-edge count; stimulus reads it 1 ns after an edge, the monitor
    // reads it on the falling edge.
    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rdata;
        int                ack_cyc;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] last_rd = 8'hFF;  // model of RDATA
    int                total   = 0;
    int                bad     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Expected completion of a request that the DUT will accept at the next
    // edge: ACK appears in the cycle after the 4th edge, plus wait states.
    task automatic push_exp(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] din, input int waits);
        exp_t e;
        e.addr    = addr;
        e.rdata   = we ? last_rd : din;
        e.ack_cyc = cyc + 4 + waits;
        if (!we) last_rd = din;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] din,
                         input int waits, input bit push);
        REQ     = 1'b1;
        WE      = we;
        ADDR_IN = addr;
        WDATA   = wd;
        D_IN    = din;
        if (push) push_exp(we, addr, din, waits);
    endtask

    task automatic wait_ack(input string name, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ACK === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_ack_seen"}, 32'(got), 32'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge CLK) begin
        if (nRES === 1'b1 && ACK === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ACK at cycle %0d, want none", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                check("ack_addr", 32'(A), 32'(e.addr));
                check("ack_rdata", 32'(RDATA), 32'(e.rdata));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        nRES    = 1'b0;
        REQ     = 1'b0;
        WE      = 1'b0;
        ADDR_IN = '0;
        WDATA   = '0;
        D_IN    = '0;
        WAIT_n  = 1'b1;
        Test1   = 1'b0;
        tick(3);

        // ---- reset values ----
        check("rst_A", 32'(A), 32'h0);
        check("rst_D_OUT", 32'(D_OUT), 32'h0);
        check("rst_D_OE", 32'(D_OE), 32'd0);
        check("rst_nRD", 32'(nRD), 32'd1);
        check("rst_nWR", 32'(nWR), 32'd1);
        check("rst_ACK", 32'(ACK), 32'd0);
        check("rst_BUSY", 32'(BUSY), 32'd0);
        check("rst_RDATA", 32'(RDATA), 32'hFF);
        check("rst_TIMEOUT", 32'(TIMEOUT), 32'd0);
        nRES = 1'b1;
        tick(2);

        // ---- write 3C to FF80 (RDATA must stay at its reset value) ----
        issue(1'b1, 16'hFF80, 8'h3C, 8'h00, 0, 1'b1);
        tick();  // T1
        check("wr_t1_A", 32'(A), 32'hFF80);
        check("wr_t1_D_OE", 32'(D_OE), 32'd1);
        check("wr_t1_D_OUT", 32'(D_OUT), 32'h3C);
        check("wr_t1_nWR", 32'(nWR), 32'd1);
        check("wr_t1_BUSY", 32'(BUSY), 32'd1);
        tick();  // T2
        check("wr_t2_nWR", 32'(nWR), 32'd0);
        check("wr_t2_nRD", 32'(nRD), 32'd1);
        tick();  // T3
        check("wr_t3_nWR", 32'(nWR), 32'd0);
        check("wr_t3_D_OE", 32'(D_OE), 32'd1);
        tick();  // T4
        check("wr_t4_ACK", 32'(ACK), 32'd1);
        check("wr_t4_nWR", 32'(nWR), 32'd1);
        check("wr_t4_D_OE", 32'(D_OE), 32'd1);
        check("wr_t4_RDATA", 32'(RDATA), 32'hFF);
        REQ = 1'b0;
        tick();  // IDLE
        check("wr_idle_ACK", 32'(ACK), 32'd0);
        check("wr_idle_D_OE", 32'(D_OE), 32'd0);
        check("wr_idle_BUSY", 32'(BUSY), 32'd0);

        // ---- zero-wait read of C000 ----
        issue(1'b0, 16'hC000, 8'h00, 8'h5A, 0, 1'b1);
        tick();  // T1
        check("rd_t1_A", 32'(A), 32'hC000);
        check("rd_t1_nRD", 32'(nRD), 32'd1);
        check("rd_t1_D_OE", 32'(D_OE), 32'd0);
        tick();  // T2
        check("rd_t2_nRD", 32'(nRD), 32'd0);
        check("rd_t2_nWR", 32'(nWR), 32'd1);
        tick();  // T3
        check("rd_t3_nRD", 32'(nRD), 32'd0);
        tick();  // T4
        check("rd_t4_ACK", 32'(ACK), 32'd1);
        check("rd_t4_nRD", 32'(nRD), 32'd1);
        check("rd_t4_RDATA", 32'(RDATA), 32'h5A);
        REQ = 1'b0;
        tick();
        check("rd_idle_BUSY", 32'(BUSY), 32'd0);

        // ---- read with two wait states ----
        issue(1'b0, 16'h1234, 8'h00, 8'hA5, 2, 1'b1);
        tick(2);     // in T2
        WAIT_n = 1'b0;
        tick(2);     // in TW
        check("w2_tw_nRD", 32'(nRD), 32'd0);
        WAIT_n = 1'b1;
        wait_ack("w2", 10);
        check("w2_TIMEOUT", 32'(TIMEOUT), 32'd0);
        REQ = 1'b0;
        tick();

        // ---- read with WAIT_n stuck low: forced completion ----
        WAIT_n = 1'b0;
        issue(1'b0, 16'h2000, 8'h00, 8'h3E, 3, 1'b1);
        tick(3);     // in TW (first wait cycle)
        check("wto_tw1_nRD", 32'(nRD), 32'd0);
        check("wto_tw1_TIMEOUT", 32'(TIMEOUT), 32'd0);
        tick(2);     // third wait cycle
        check("wto_tw3_TIMEOUT", 32'(TIMEOUT), 32'd0);
        check("wto_tw3_BUSY", 32'(BUSY), 32'd1);
        tick();      // forced T3
        check("wto_t3_TIMEOUT", 32'(TIMEOUT), 32'd1);
        check("wto_t3_nRD", 32'(nRD), 32'd0);
        wait_ack("wto", 10);
        WAIT_n = 1'b1;
        REQ = 1'b0;
        tick();

        // ---- back-to-back reads, REQ held ----
        issue(1'b0, 16'h0100, 8'h00, 8'h11, 0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("b2b_BUSY", 32'(BUSY), 32'd1);
            if (i == 4) begin
                check("b2b_ack1", 32'(ACK), 32'd1);
                ADDR_IN = 16'h0101;
                D_IN    = 8'h22;
                push_exp(1'b0, 16'h0101, 8'h22, 0);
            end
        end
        check("b2b_ack2", 32'(ACK), 32'd1);
        check("b2b_RDATA", 32'(RDATA), 32'h22);
        check("b2b_TIMEOUT_sticky", 32'(TIMEOUT), 32'd1);
        REQ = 1'b0;
        tick();
        check("b2b_idle_BUSY", 32'(BUSY), 32'd0);

        // ---- Test1 raised during T2 of a write ----
        issue(1'b1, 16'h0040, 8'h77, 8'h00, 0, 1'b0);
        tick(2);     // T2
        check("t1_t2_nWR", 32'(nWR), 32'd0);
        check("t1_t2_D_OE", 32'(D_OE), 32'd1);
        Test1 = 1'b1;
        tick();      // aborted
        check("t1_abort_nWR", 32'(nWR), 32'd1);
        check("t1_abort_D_OE", 32'(D_OE), 32'd0);
        check("t1_abort_BUSY", 32'(BUSY), 32'd0);
        check("t1_abort_ACK", 32'(ACK), 32'd0);
        tick();      // still disabled, REQ held
        check("t1_hold_BUSY", 32'(BUSY), 32'd0);
        check("t1_hold_RDATA", 32'(RDATA), 32'h22);
        Test1 = 1'b0;
        push_exp(1'b1, 16'h0040, 8'h00, 0);
        tick();      // T1 again
        check("t1_rerun_D_OUT", 32'(D_OUT), 32'h77);
        wait_ack("t1_rerun", 10);
        REQ = 1'b0;
        tick();

        // ---- async reset during T3 of a read ----
        issue(1'b0, 16'h3333, 8'h00, 8'h99, 0, 1'b0);
        tick(3);     // T3
        check("rs_t3_nRD", 32'(nRD), 32'd0);
        #2;
        nRES = 1'b0;
        REQ  = 1'b0;
        #1;
        check("rs_A", 32'(A), 32'h0);
        check("rs_nRD", 32'(nRD), 32'd1);
        check("rs_BUSY", 32'(BUSY), 32'd0);
        check("rs_RDATA", 32'(RDATA), 32'hFF);
        check("rs_TIMEOUT", 32'(TIMEOUT), 32'd0);
        check("rs_D_OUT", 32'(D_OUT), 32'h0);
        last_rd = 8'hFF;
        #3;
        nRES = 1'b1;
        tick(2);
        issue(1'b0, 16'h4444, 8'h00, 8'hC3, 0, 1'b1);
        wait_ack("rs_restart", 10);
        check("rs_restart_RDATA", 32'(RDATA), 32'hC3);
        REQ = 1'b0;
        tick(3);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ext_bus_sequencer
